vec_load_unit: RTL and testbench
================================

VEC_LOAD_UNIT -- requirements
Module: vec_load_unit

Interface
REQ-001 Parameter registerSize, default 8, SHALL set the bit width of one vector lane.
REQ-002 Parameter vectorSize, default 4, SHALL set the number of lanes per vector.
REQ-003 Parameter addrWidth, default 16, SHALL set the memory address width.
REQ-004 Parameter timeoutCycles, default 255, SHALL set the maximum number of cycles to wait per memory beat.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-007 start  in  1  SHALL be a load request, sampled only in IDLE.
REQ-008 baseAddr  in  addrWidth  SHALL be the address of lane 0, sampled with start.
REQ-009 destReg  in  3  SHALL be the destination vector register index, sampled with start.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 done  out  1  SHALL pulse for one cycle when a vector write is issued.
REQ-012 error  out  1  SHALL pulse for one cycle when a load is aborted on timeout.
REQ-013 memRdReq  out  1  SHALL be the memory read request.
REQ-014 memAddr  out  addrWidth  SHALL be the read address, valid while memRdReq is high.
REQ-015 memRdValid  in  1  SHALL indicate that memRdData is valid.
REQ-016 memRdData  in  registerSize  SHALL be the read data for the current beat.
REQ-017 regWrEn  out  1  SHALL be the register-file write enable.
REQ-018 regToWrite  out  3  SHALL be the register-file write index.
REQ-019 regWriteData  out  [vectorSize][registerSize]  SHALL be the packed vector write data, with lane k in element k.

Function
REQ-020 States SHALL be IDLE, REQ and WRITE.
REQ-021 In IDLE, if start=1, the unit SHALL latch baseAddr and destReg, clear the lane index and the timeout counter, and enter REQ on the next cycle.
REQ-022 In REQ, memRdReq SHALL be 1 and memAddr SHALL be baseAddr+lane, computed modulo 2^addrWidth (wrap-around, no flag).
REQ-023 A beat SHALL complete in any cycle where memRdReq=1 and memRdValid=1: memRdData is captured into lane[index], the index increments and the timeout counter clears.
REQ-024 After completing beat vectorSize-1, the unit SHALL enter WRITE; otherwise it SHALL stay in REQ and issue the next address in the following cycle.
REQ-025 In WRITE, regWrEn, regToWrite=destReg, the full regWriteData and done SHALL all be asserted for exactly one cycle, followed by IDLE.
REQ-026 Minimum latency from start to regWrEn SHALL be vectorSize+1 cycles, given zero-wait memory.
REQ-027 If the timeout counter reaches timeoutCycles in REQ without memRdValid, the unit SHALL pulse error, return to IDLE and SHALL NOT assert regWrEn.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 memRdValid SHALL be ignored when memRdReq=0.
REQ-030 All control outputs (memRdReq, regWrEn, done, error) SHALL be registered and glitch-free, because regWrEn gates the register-file clock.
REQ-031 regWriteData SHALL hold the last assembled vector outside WRITE.

Reset
REQ-032 reset=1 SHALL force IDLE; busy, done, error, memRdReq and regWrEn to 0; memAddr, regToWrite, regWriteData, the lane index and the timeout counter to 0.
REQ-033 A reset asserted mid-load SHALL discard partial lanes, and no register write SHALL follow it.

Structure
REQ-034 Shared package vec_pkg SHALL hold the state enum, the default registerSize/vectorSize/addrWidth values, and the default timeout constant.
REQ-035 Lane assembly SHALL be a sub-module vec_lane_buffer (per-lane load enable plus clear), with the FSM, address and timeout logic in vec_load_unit.

Verification
REQ-036 baseAddr=0x0010, destReg=5, memory returns 0x11,0x22,0x33,0x44 with zero wait -> regWrEn one cycle at start+5, regToWrite=5, lanes {0x11,0x22,0x33,0x44}, done pulse.
REQ-037 baseAddr=0xFFFE, vectorSize=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 memRdValid withheld 3 cycles on beat 2 -> memAddr holds base+2 throughout, correct vector written, latency +3.
REQ-039 memRdValid never asserted on beat 1 -> error pulse after 255 cycles, no regWrEn, busy=0.
REQ-040 reset asserted after beat 2 -> IDLE next cycle, no regWrEn; a new start with destReg=2 then loads cleanly.
REQ-041 start pulsed while busy -> ignored; only the first destReg is written.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and default sizing for the vector load unit.
package vec_pkg;

  localparam int unsigned REG_SIZE       = 8;
  localparam int unsigned VEC_SIZE       = 4;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_lane_buffer.sv
// Lane assembly buffer: per-lane capture plus a committed output vector that
// holds the last complete load until the next commit.
module vec_lane_buffer #(
  parameter int unsigned registerSize = 8,
  parameter int unsigned vectorSize   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic [vectorSize-1:0]                  load,
  input  logic [registerSize-1:0]                din,
  input  logic                                   commit,
  output logic [vectorSize-1:0][registerSize-1:0] vec
);

  logic [vectorSize-1:0][registerSize-1:0] lanes;
  logic [vectorSize-1:0][registerSize-1:0] assembled;

  // Merge the beat arriving this cycle so commit sees the final lane too.
  always_comb begin
    assembled = lanes;
    for (int k = 0; k < int'(vectorSize); k++) begin
      if (load[k]) assembled[k] = din;
    end
  end

  // Working lanes; cleared at the start of each load and on reset.
  always_ff @(posedge clk) begin
    if (reset || clear) lanes <= '0;
    else                lanes <= assembled;
  end

  // Committed vector, stable outside the write cycle.
  always_ff @(posedge clk) begin
    if (reset)       vec <= '0;
    else if (commit) vec <= assembled;
  end

endmodule

// File: rtl/vec_load_unit.sv
// Vector load unit: fetches vectorSize lanes from memory one beat at a time,
// then writes the assembled vector to the register file in a single cycle.
module vec_load_unit
  import vec_pkg::*;
#(
  parameter int unsigned registerSize  = REG_SIZE,
  parameter int unsigned vectorSize    = VEC_SIZE,
  parameter int unsigned addrWidth     = ADDR_W,
  parameter int unsigned timeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [addrWidth-1:0]                    baseAddr,
  input  logic [2:0]                              destReg,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  output logic                                    memRdReq,
  output logic [addrWidth-1:0]                    memAddr,
  input  logic                                    memRdValid,
  input  logic [registerSize-1:0]                 memRdData,
  output logic                                    regWrEn,
  output logic [2:0]                              regToWrite,
  output logic [vectorSize-1:0][registerSize-1:0] regWriteData
);

  localparam int unsigned IDX_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam int unsigned TO_W  = $clog2(timeoutCycles + 1);

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    lane_idx;
  logic [TO_W-1:0]     to_cnt;
  logic [2:0]          dest_q;
  logic                load_start;
  logic                beat;
  logic                last_beat;
  logic                timeout_hit;
  logic [vectorSize-1:0] lane_load;
  logic                busy_d;
  logic                done_d;
  logic                error_d;
  logic                mem_rd_req_d;
  logic                reg_wr_en_d;

  assign load_start  = (state == ST_IDLE) && start;
  assign beat        = memRdReq && memRdValid;
  assign last_beat   = beat && (lane_idx == IDX_W'(vectorSize - 1));
  assign timeout_hit = memRdReq && !memRdValid && (to_cnt == TO_W'(timeoutCycles - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_REQ;
      ST_REQ: begin
        if (last_beat)        next_state = ST_WRITE;
        else if (timeout_hit) next_state = ST_IDLE;
      end
      ST_WRITE: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state; flopped below so controls are glitch-free.
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    mem_rd_req_d = 1'b0;
    reg_wr_en_d  = 1'b0;
    busy_d       = (next_state != ST_IDLE);
    mem_rd_req_d = (next_state == ST_REQ);
    reg_wr_en_d  = (next_state == ST_WRITE);
    done_d       = (next_state == ST_WRITE);
    error_d      = (state == ST_REQ) && timeout_hit;
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      memRdReq <= 1'b0;
      regWrEn  <= 1'b0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      memRdReq <= mem_rd_req_d;
      regWrEn  <= reg_wr_en_d;
    end
  end

  // Address, lane index, timeout counter and destination tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      memAddr    <= '0;
      lane_idx   <= '0;
      to_cnt     <= '0;
      dest_q     <= '0;
      regToWrite <= '0;
    end else begin
      if (load_start) begin
        memAddr  <= baseAddr;
        dest_q   <= destReg;
        lane_idx <= '0;
        to_cnt   <= '0;
      end else if (beat) begin
        memAddr  <= memAddr + addrWidth'(1);
        lane_idx <= last_beat ? '0 : lane_idx + IDX_W'(1);
        to_cnt   <= '0;
      end else if (memRdReq) begin
        to_cnt   <= timeout_hit ? '0 : to_cnt + TO_W'(1);
      end
      if (next_state == ST_WRITE) regToWrite <= dest_q;
    end
  end

  // One-hot lane select for the beat completing this cycle.
  always_comb begin
    lane_load = '0;
    for (int k = 0; k < int'(vectorSize); k++) begin
      lane_load[k] = beat && (lane_idx == IDX_W'(k));
    end
  end

  vec_lane_buffer #(
    .registerSize(registerSize),
    .vectorSize  (vectorSize)
  ) u_lane_buffer (
    .clk   (clk),
    .reset (reset),
    .clear (load_start),
    .load  (lane_load),
    .din   (memRdData),
    .commit(last_beat),
    .vec   (regWriteData)
  );

endmodule

// File: tb/tb_vec_load_unit.sv
// Bench for vec_load_unit: scenario tasks against a memory-image reference model.
module tb_vec_load_unit;

  localparam int VS = 4;
  localparam int TO = 255;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [15:0]     baseAddr;
  logic [2:0]      destReg;
  logic            busy;
  logic            done;
  logic            error;
  logic            memRdReq;
  logic [15:0]     memAddr;
  logic            memRdValid;
  logic [7:0]      memRdData;
  logic            regWrEn;
  logic [2:0]      regToWrite;
  logic [3:0][7:0] regWriteData;

  always #5 clk = ~clk;

  vec_load_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .baseAddr    (baseAddr),
    .destReg     (destReg),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .memRdReq    (memRdReq),
    .memAddr     (memAddr),
    .memRdValid  (memRdValid),
    .memRdData   (memRdData),
    .regWrEn     (regWrEn),
    .regToWrite  (regToWrite),
    .regWriteData(regWriteData)
  );

  logic [7:0] mem [0:65535];
  int n_vec = 0;
  int n_bad = 0;

  // Observations gathered by do_load.
  int          t, wr_count, wr_t, done_count, done_t, err_count, err_t, hang;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic        busy_at_err, busy_after_rst, req_after_rst;
  logic [15:0] req_addr_q[$];
  int          req_beat_q[$];

  // Expected vector: lane k comes from base+k modulo 2^16.
  function automatic logic [31:0] model_vec(input logic [15:0] base);
    logic [31:0] v;
    for (int k = 0; k < VS; k++) v[k*8 +: 8] = mem[16'(base + 16'(k))];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one load with a behavioural memory; w<0 withholds valid forever on that beat.
  task automatic do_load(input logic [15:0] base, input logic [2:0] dest,
                         input int w0, input int w1, input int w2, input int w3,
                         input int rst_beat, input bit spurious);
    int waits[4];
    int waited;
    int beats;
    bit fin;
    waits = '{w0, w1, w2, w3};
    waited = 0; beats = 0; fin = 1'b0;
    wr_count = 0; wr_t = -1; done_count = 0; done_t = -1; err_count = 0; err_t = -1; hang = 0;
    wr_reg = '0; wr_data = '0; busy_at_err = 1'b1; busy_after_rst = 1'b1; req_after_rst = 1'b1;
    req_addr_q.delete(); req_beat_q.delete();
    baseAddr = base; destReg = dest; start = 1'b1; memRdValid = 1'b0; t = 0;
    for (int c = 0; c < 700 && !fin; c++) begin
      step(); t++;
      start = 1'b0;
      if (spurious && t == 2) begin start = 1'b1; destReg = ~dest; baseAddr = ~base; end
      if (regWrEn) begin wr_count++; wr_t = t; wr_reg = regToWrite; wr_data = regWriteData; end
      if (done) begin done_count++; done_t = t; end
      if (error) begin err_count++; err_t = t; busy_at_err = busy; end
      if (!busy) fin = 1'b1;
      else if (memRdReq) begin
        req_addr_q.push_back(memAddr); req_beat_q.push_back(beats);
        if (rst_beat >= 0 && beats == rst_beat) begin
          reset = 1'b1; memRdValid = 1'b0;
          step(); t++;
          reset = 1'b0;
          busy_after_rst = busy; req_after_rst = memRdReq;
          if (regWrEn) wr_count++;
          fin = 1'b1;
        end else if (beats < VS && (waits[beats] < 0 || waited < waits[beats])) begin
          memRdValid = 1'b0; memRdData = 8'($urandom); waited++;
        end else begin
          memRdValid = 1'b1; memRdData = mem[memAddr]; beats++; waited = 0;
        end
      end else begin
        memRdValid = 1'($urandom_range(0, 1)); memRdData = 8'($urandom);
      end
    end
    if (!fin) hang = 1;
    for (int c = 0; c < 8; c++) begin
      step(); t++;
      if (regWrEn) wr_count++;
      if (done) done_count++;
      if (error) err_count++;
      memRdValid = 1'($urandom_range(0, 1)); memRdData = 8'($urandom);
    end
    memRdValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; memRdValid = 1'b1;
    step(); step();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", error); end
    n_vec++; if (memRdReq !== 1'b0) begin n_bad++; $display("FAIL reset_memRdReq got=%b exp=0", memRdReq); end
    n_vec++; if (regWrEn !== 1'b0) begin n_bad++; $display("FAIL reset_regWrEn got=%b exp=0", regWrEn); end
    n_vec++; if (memAddr !== 16'h0) begin n_bad++; $display("FAIL reset_memAddr got=%h exp=0000", memAddr); end
    n_vec++; if (regToWrite !== 3'd0) begin n_bad++; $display("FAIL reset_regToWrite got=%0d exp=0", regToWrite); end
    n_vec++; if (regWriteData !== 32'h0) begin n_bad++; $display("FAIL reset_regWriteData got=%h exp=0", regWriteData); end
    reset = 1'b0; start = 1'b0; memRdValid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    do_load(16'h0010, 3'd5, 0, 0, 0, 0, -1, 1'b0);
    n_vec++; if (hang !== 0) begin n_bad++; $display("FAIL basic_hang got=%0d exp=0", hang); end
    n_vec++; if (wr_count !== 1) begin n_bad++; $display("FAIL basic_wr_count got=%0d exp=1", wr_count); end
    n_vec++; if (wr_t !== 5) begin n_bad++; $display("FAIL basic_latency got=%0d exp=5", wr_t); end
    n_vec++; if (wr_reg !== 3'd5) begin n_bad++; $display("FAIL basic_reg got=%0d exp=5", wr_reg); end
    n_vec++; if (wr_data !== 32'h44332211) begin n_bad++; $display("FAIL basic_data got=%h exp=44332211", wr_data); end
    n_vec++; if (done_count !== 1 || done_t !== 5) begin n_bad++; $display("FAIL basic_done got=%0d@%0d exp=1@5", done_count, done_t); end
    n_vec++; if (err_count !== 0) begin n_bad++; $display("FAIL basic_error got=%0d exp=0", err_count); end
    n_vec++; if (regWriteData !== 32'h44332211) begin n_bad++; $display("FAIL basic_hold got=%h exp=44332211", regWriteData); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_load(16'hFFFE, 3'd3, 0, 0, 0, 0, -1, 1'b0);
    n_vec++; if (req_addr_q.size() !== 4) begin n_bad++; $display("FAIL wrap_nreq got=%0d exp=4", req_addr_q.size()); end
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++) begin
      n_vec++; if (req_addr_q[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, req_addr_q[i], exp_a[i]); end
    end
    n_vec++; if (wr_data !== model_vec(16'hFFFE)) begin n_bad++; $display("FAIL wrap_data got=%h exp=%h", wr_data, model_vec(16'hFFFE)); end
  endtask

  task automatic test_wait();
    logic [15:0] b;
    int n2;
    b = 16'h1200; n2 = 0;
    do_load(b, 3'd1, 0, 0, 3, 0, -1, 1'b0);
    for (int i = 0; i < req_addr_q.size(); i++) begin
      if (req_beat_q[i] == 2) begin
        n2++;
        n_vec++; if (req_addr_q[i] !== 16'(b + 16'd2)) begin n_bad++; $display("FAIL wait_addr got=%h exp=%h", req_addr_q[i], 16'(b + 16'd2)); end
      end
    end
    n_vec++; if (n2 !== 4) begin n_bad++; $display("FAIL wait_beat2_cycles got=%0d exp=4", n2); end
    n_vec++; if (wr_t !== 8) begin n_bad++; $display("FAIL wait_latency got=%0d exp=8", wr_t); end
    n_vec++; if (wr_data !== model_vec(b)) begin n_bad++; $display("FAIL wait_data got=%h exp=%h", wr_data, model_vec(b)); end
  endtask

  task automatic test_timeout();
    // Beat 1 is requested in cycle 2; after TO idle cycles the abort shows one cycle later.
    do_load(16'h0400, 3'd4, 0, -1, 0, 0, -1, 1'b0);
    n_vec++; if (err_count !== 1) begin n_bad++; $display("FAIL timeout_err_count got=%0d exp=1", err_count); end
    n_vec++; if (err_t !== 2 + TO) begin n_bad++; $display("FAIL timeout_err_cycle got=%0d exp=%0d", err_t, 2 + TO); end
    n_vec++; if (busy_at_err !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got=%b exp=0", busy_at_err); end
    n_vec++; if (wr_count !== 0) begin n_bad++; $display("FAIL timeout_wr got=%0d exp=0", wr_count); end
    n_vec++; if (done_count !== 0) begin n_bad++; $display("FAIL timeout_done got=%0d exp=0", done_count); end
  endtask

  task automatic test_reset_midload();
    do_load(16'h2000, 3'd7, 0, 0, 0, 0, 2, 1'b0);
    n_vec++; if (busy_after_rst !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy_after_rst); end
    n_vec++; if (req_after_rst !== 1'b0) begin n_bad++; $display("FAIL rst_memRdReq got=%b exp=0", req_after_rst); end
    n_vec++; if (wr_count !== 0) begin n_bad++; $display("FAIL rst_wr got=%0d exp=0", wr_count); end
    n_vec++; if (regWriteData !== 32'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", regWriteData); end
    do_load(16'h3000, 3'd2, 0, 0, 0, 0, -1, 1'b0);
    n_vec++; if (wr_count !== 1) begin n_bad++; $display("FAIL rst_reload_wr got=%0d exp=1", wr_count); end
    n_vec++; if (wr_reg !== 3'd2) begin n_bad++; $display("FAIL rst_reload_reg got=%0d exp=2", wr_reg); end
    n_vec++; if (wr_data !== model_vec(16'h3000)) begin n_bad++; $display("FAIL rst_reload_data got=%h exp=%h", wr_data, model_vec(16'h3000)); end
  endtask

  task automatic test_busy_start();
    do_load(16'h0500, 3'd6, 0, 1, 0, 0, -1, 1'b1);
    n_vec++; if (wr_count !== 1) begin n_bad++; $display("FAIL busy_start_wr got=%0d exp=1", wr_count); end
    n_vec++; if (wr_reg !== 3'd6) begin n_bad++; $display("FAIL busy_start_reg got=%0d exp=6", wr_reg); end
    n_vec++; if (wr_data !== model_vec(16'h0500)) begin n_bad++; $display("FAIL busy_start_data got=%h exp=%h", wr_data, model_vec(16'h0500)); end
    n_vec++; if (req_addr_q.size() !== 5) begin n_bad++; $display("FAIL busy_start_nreq got=%0d exp=5", req_addr_q.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [15:0] b;
      logic [2:0]  d;
      int w[4];
      int sw;
      b = 16'($urandom); d = 3'($urandom);
      sw = 0;
      for (int k = 0; k < 4; k++) begin w[k] = $urandom_range(0, 3); sw += w[k]; end
      do_load(b, d, w[0], w[1], w[2], w[3], -1, 1'b0);
      n_vec++; if (hang !== 0) begin n_bad++; $display("FAIL rnd%0d_hang got=%0d exp=0", it, hang); end
      n_vec++; if (wr_count !== 1 || done_count !== 1 || err_count !== 0) begin n_bad++;
        $display("FAIL rnd%0d_pulses got=wr%0d/done%0d/err%0d exp=1/1/0", it, wr_count, done_count, err_count); end
      n_vec++; if (wr_t !== VS + 1 + sw) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, wr_t, VS + 1 + sw); end
      n_vec++; if (wr_reg !== d) begin n_bad++; $display("FAIL rnd%0d_reg got=%0d exp=%0d", it, wr_reg, d); end
      n_vec++; if (wr_data !== model_vec(b)) begin n_bad++; $display("FAIL rnd%0d_data got=%h exp=%h", it, wr_data, model_vec(b)); end
      n_vec++; if (regWriteData !== model_vec(b)) begin n_bad++; $display("FAIL rnd%0d_hold got=%h exp=%h", it, regWriteData, model_vec(b)); end
      n_vec++; if (req_addr_q.size() !== VS + sw) begin n_bad++; $display("FAIL rnd%0d_nreq got=%0d exp=%0d", it, req_addr_q.size(), VS + sw); end
      for (int i = 0; i < req_addr_q.size(); i++) begin
        n_vec++; if (req_addr_q[i] !== 16'(b + 16'(req_beat_q[i]))) begin n_bad++;
          $display("FAIL rnd%0d_addr%0d got=%h exp=%h", it, i, req_addr_q[i], 16'(b + 16'(req_beat_q[i]))); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; baseAddr = '0; destReg = '0;
    memRdValid = 1'b0; memRdData = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_wait();
    test_timeout();
    test_reset_midload();
    test_busy_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
